write_rw: RTL and testbench
===========================

Name: write_rw

Overview:
- Write-back stage for task read-write objects: after a task finishes modifying its RW object, this block writes the 32-bit object into memory over an AW/W/B channel set.
- On the B response, forwards the task (descriptor, CQ slot, thread) downstream.
- Tasks carrying no modification bypass memory.
- Sits between the task-execute stage and the finish/commit path; it is the write-side counterpart to the RW read stage.

Parameters:
N_THREADS, 16, number of thread contexts; sizes the per-thread pending store (indexed by thread_id_t).
RW_ARSIZE, 2, log2 bytes per RW object; only 2 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
task_in_valid  in  1  input task valid
task_in_ready  out  1  input task accepted
task_in  in  rw_write_t  task_desc, cq_slot, thread, object (32b), cache_addr
task_in_wr  in  1  1 = object modified and must be written; 0 = bypass
awvalid  out  1  write address valid
awready  in  1  write address accept
awaddr  out  32  byte address of object
awid  out  id_t  = task_in.thread
wvalid  out  1  write data valid
wready  in  1  write data accept
wdata  out  512  object replicated 16x
wstrb  out  64  4'hF at word locale[3:0], else 0
bvalid  in  1  write response valid
bready  out  1  write response accept
bid  in  id_t  thread of completed write
task_out_valid  out  1  completed task valid
task_out_ready  in  1  downstream accept
task_out  out  rw_write_t  completed task (object field = written value)
reg_bus  ifc  reg_bus_t  register access

Behaviour:
- Reset values: awvalid, wvalid, task_out_valid, task_in_ready, bready = 0; aw_done, w_done, pending[] = 0; base_rw_addr = 0; err_sticky = 0.
- awaddr = base_rw_addr + (task_in.task_desc.locale << RW_ARSIZE), computed modulo 2^32.
- Write path (task_in_valid & task_in_wr):
  - awvalid = task_in_valid & task_in_wr & !aw_done; wvalid = task_in_valid & task_in_wr & !w_done.
  - AW and W handshake independently. aw_done / w_done latch their handshakes.
  - task_in_ready = 1 in the cycle the last outstanding channel handshakes, i.e. (aw_done | awvalid&awready) & (w_done | wvalid&wready). Same-cycle completion of both channels is legal: latency 1 cycle.
  - On accept: clear aw_done / w_done; store the task in slot[task_in.thread]; set pending[thread].
  - A write whose thread already has pending set is held: awvalid = wvalid = 0 until that pending bit clears.
- Bypass path (task_in_valid & !task_in_wr):
  - No memory traffic.
  - task_out_valid = 1 with task_out = task_in, provided bvalid = 0.
  - task_in_ready = task_out_ready & !bvalid.
- Response path:
  - On bvalid: task_out = slot[bid], task_out_valid = 1, bready = task_out_ready.
  - On B handshake, clear pending[bid].
  - B has priority over bypass. Combinational valid/ready, no added latency.
- Simultaneous B clear and new accept on the same thread: the accept is blocked (pending still set that cycle); it is taken the next cycle.
- bid with pending clear:
  - response is consumed (bready = task_out_ready) and task_out_valid = 0.
  - err_sticky is set.
- Register bus:
  - write RW_BASE_ADDR: base_rw_addr <= {wdata[29:0], 2'b00}.
  - read RW_WRITE_ERR: returns {31'b0, err_sticky}; all other addresses read 0.
  - rvalid <= arvalid, 1 cycle.
- Reset mid-operation: all state cleared, including latched channel flags and pending bits; in-flight responses then take the error path. The memory side and downstream reset together.

Optional Feature:
WRITE_RW_STATS_EN
- Defined: 32-bit saturating counters n_writes (write accepts), n_bypass, n_stall_cycles (task_in_valid & !task_in_ready).
  - Read at RW_WRITE_STAT_BASE + 0/4/8; reset to 0.
  - Writing any value to RW_WRITE_STAT_BASE clears all three counters.
- Undefined: counters absent; those addresses read 0.

Decomposition:
- swarm package: rw_write_t, id_t, thread_id_t, task_t, cq_slice_slot_t, RW_ARSIZE, and register addresses RW_BASE_ADDR, RW_WRITE_ERR, RW_WRITE_STAT_BASE.
- One sub-module is natural: write_rw_slot_store, the N_THREADS-entry descriptor RAM plus pending bitmap with set/clear/lookup ports.

Test Plan:
- Base=0x1000, write locale=5, object=0xDEADBEEF, awready=wready=1 → awaddr=0x1014; wstrb bit group 5 = 4'hF, all others 0; ready same cycle; bvalid bid=thread 3 → task_out_valid, object 0xDEADBEEF, thread 3.
- awready=1 at cycle 0, wready held 0 until cycle 4 → awvalid drops after cycle 0; ready asserted only in cycle 4; exactly one AW handshake.
- Bypass task with task_out_ready=1 while bvalid=1 → B task emitted first; bypass emitted next cycle; no AW/W activity.
- Second write on thread 2 while pending[2] set → no awvalid until B for bid=2 handshakes; issue follows in the next cycle.
- bvalid with bid=7, pending[7]=0 → bready=1, task_out_valid=0; RW_WRITE_ERR read returns 1.
- Reset asserted with aw_done set → next task reissues both AW and W; pending cleared; base address reads as 0 in awaddr.

Source files
------------

// File: rtl/write_rw_pkg.sv
// Shared types, register map and helpers for the RW write-back stage.
// The optional statistics block is enabled by defining WRITE_RW_STATS_EN.
package write_rw_pkg;

  localparam int THREAD_W  = 4;
  localparam int RW_ARSIZE = 2;

  localparam logic [15:0] RW_BASE_ADDR       = 16'h0000;
  localparam logic [15:0] RW_WRITE_ERR       = 16'h0004;
  localparam logic [15:0] RW_WRITE_STAT_BASE = 16'h0010;

  typedef logic [THREAD_W-1:0] thread_id_t;
  typedef logic [THREAD_W-1:0] id_t;
  typedef logic [7:0]          cq_slice_slot_t;

  typedef struct packed {
    logic [31:0] ts;
    logic [15:0] locale;
    logic [7:0]  ttype;
  } task_t;

  typedef struct packed {
    task_t          task_desc;
    cq_slice_slot_t cq_slot;
    thread_id_t     thread;
    logic [31:0]    object;
    logic [31:0]    cache_addr;
  } rw_write_t;

  typedef struct packed {
    logic        wvalid;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        arvalid;
    logic [15:0] araddr;
  } reg_bus_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
  } reg_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/write_rw_slot_store.sv
// Per-thread store of in-flight write tasks plus the pending bitmap that
// tracks which threads still await their B response.
module write_rw_slot_store
  import write_rw_pkg::*;
#(
  parameter int N_THREADS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set_en,
  input  thread_id_t i_set_idx,
  input  rw_write_t  i_set_data,
  input  logic       i_clr_en,
  input  thread_id_t i_clr_idx,
  input  thread_id_t i_lk_idx,
  output logic       o_lk_pending,
  input  thread_id_t i_rd_idx,
  output rw_write_t  o_rd_data,
  output logic       o_rd_pending
);

  logic [N_THREADS-1:0] r_pending;
  rw_write_t            r_slot [N_THREADS];

  // A set and a clear never target the same thread in one cycle: a set
  // requires the bit to be clear, a clear requires it to be set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (i_clr_en) r_pending[i_clr_idx] <= 1'b0;
      if (i_set_en) r_pending[i_set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_set_en) r_slot[i_set_idx] <= i_set_data;
  end

  assign o_lk_pending = r_pending[i_lk_idx];
  assign o_rd_pending = r_pending[i_rd_idx];
  assign o_rd_data    = r_slot[i_rd_idx];

endmodule

// File: rtl/write_rw.sv
// RW write-back stage: writes modified RW objects over AW/W/B and forwards
// completed tasks. Optional counters are enabled by WRITE_RW_STATS_EN.
module write_rw
  import write_rw_pkg::*;
#(
  parameter int N_THREADS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         task_in_valid,
  output logic         task_in_ready,
  input  rw_write_t    task_in,
  input  logic         task_in_wr,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  awaddr,
  output id_t          awid,
  output logic         wvalid,
  input  logic         wready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  input  logic         bvalid,
  output logic         bready,
  input  id_t          bid,
  output logic         task_out_valid,
  input  logic         task_out_ready,
  output rw_write_t    task_out,
  input  reg_bus_t     reg_bus,
  output reg_rsp_t     reg_rsp
);

  // Handshake rule for every channel: a transfer happens in a cycle where
  // valid and ready are both high; all valids and readies here are
  // combinational and may depend on the peer's signals of the same cycle.

  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_base;
  logic        r_err;
  reg_rsp_t    r_rsp;

  logic        w_in_pending;
  logic        w_b_pending;
  rw_write_t   w_b_task;
  logic        w_wr_req;
  logic        w_bypass_req;
  logic        w_wr_go;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wr_accept;
  logic        w_b_act;
  logic        w_bypass_accept;
  logic [31:0] w_rdata;

  write_rw_slot_store #(
    .N_THREADS (N_THREADS)
  ) u_slot_store (
    .clk          (clk),
    .rst          (rst),
    .i_set_en     (w_wr_accept),
    .i_set_idx    (task_in.thread),
    .i_set_data   (task_in),
    .i_clr_en     (bready & w_b_pending),
    .i_clr_idx    (bid),
    .i_lk_idx     (task_in.thread),
    .o_lk_pending (w_in_pending),
    .i_rd_idx     (bid),
    .o_rd_data    (w_b_task),
    .o_rd_pending (w_b_pending)
  );

  // Registered pending bit blocks a same-thread write for the cycle its B
  // response retires, so the new write issues one cycle later.
  always_comb begin
    w_wr_req        = !rst & task_in_valid & task_in_wr;
    w_bypass_req    = !rst & task_in_valid & !task_in_wr;
    w_wr_go         = w_wr_req & !w_in_pending;
    awvalid         = w_wr_go & !r_aw_done;
    wvalid          = w_wr_go & !r_w_done;
    w_aw_hs         = awvalid & awready;
    w_w_hs          = wvalid & wready;
    w_wr_accept     = w_wr_go & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    w_b_act         = !rst & bvalid;
    bready          = w_b_act & task_out_ready;
    w_bypass_accept = w_bypass_req & task_out_ready & !bvalid;
    task_in_ready   = w_wr_accept | w_bypass_accept;
    task_out_valid  = w_b_act ? w_b_pending : w_bypass_req;
    task_out        = w_b_act ? w_b_task : task_in;
  end

  assign awaddr = r_base + (32'(task_in.task_desc.locale) << RW_ARSIZE);
  assign awid   = task_in.thread;
  assign wdata  = {16{task_in.object}};
  assign wstrb  = 64'hF << {task_in.task_desc.locale[3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_accept) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // A response for a thread with nothing outstanding is drained and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (bready & !w_b_pending) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
    end else if (reg_bus.wvalid && reg_bus.waddr == RW_BASE_ADDR) begin
      r_base <= reg_bus.wdata << 2;
    end
  end

`ifdef WRITE_RW_STATS_EN
  logic [31:0] r_n_writes;
  logic [31:0] r_n_bypass;
  logic [31:0] r_n_stall;
  logic        w_stat_clr;

  assign w_stat_clr = reg_bus.wvalid && reg_bus.waddr == RW_WRITE_STAT_BASE;

  always_ff @(posedge clk) begin
    if (rst || w_stat_clr) begin
      r_n_writes <= '0;
      r_n_bypass <= '0;
      r_n_stall  <= '0;
    end else begin
      if (w_wr_accept)                    r_n_writes <= sat_inc(r_n_writes);
      if (w_bypass_accept)                r_n_bypass <= sat_inc(r_n_bypass);
      if (task_in_valid & !task_in_ready) r_n_stall  <= sat_inc(r_n_stall);
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (reg_bus.araddr == RW_WRITE_ERR) begin
      w_rdata = {31'b0, r_err};
    end
`ifdef WRITE_RW_STATS_EN
    else if (reg_bus.araddr == RW_WRITE_STAT_BASE) begin
      w_rdata = r_n_writes;
    end else if (reg_bus.araddr == RW_WRITE_STAT_BASE + 16'd4) begin
      w_rdata = r_n_bypass;
    end else if (reg_bus.araddr == RW_WRITE_STAT_BASE + 16'd8) begin
      w_rdata = r_n_stall;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else begin
      r_rsp.rvalid <= reg_bus.arvalid;
      r_rsp.rdata  <= w_rdata;
    end
  end

  assign reg_rsp = r_rsp;

endmodule

// File: tb/tb_write_rw.sv
// Bench for write_rw: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_write_rw;
  import write_rw_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         task_in_valid, task_in_ready, task_in_wr;
  rw_write_t    task_in;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  awaddr;
  id_t          awid, bid;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         task_out_valid, task_out_ready;
  rw_write_t    task_out;
  reg_bus_t     reg_bus;
  reg_rsp_t     reg_rsp;

  int n_cmp = 0;
  int n_bad = 0;

  write_rw dut (
    .clk(clk), .rst(rst),
    .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
    .task_in(task_in), .task_in_wr(task_in_wr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .task_out_valid(task_out_valid), .task_out_ready(task_out_ready),
    .task_out(task_out), .reg_bus(reg_bus), .reg_rsp(reg_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A write task needs one address beat and one data beat; it is retired
  // from the input once both have been delivered, and then waits for its
  // response in the per-thread outstanding table.
  logic        m_out[16];
  rw_write_t   m_slot[16];
  logic        m_addr_sent = 1'b0;
  logic        m_data_sent = 1'b0;
  logic [31:0] m_base = '0;
  logic        m_err = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_cnt[3];

  initial begin
    for (int i = 0; i < 16; i++) m_out[i] = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = '0;
  end

  logic      e_hold, e_wr, e_awvalid, e_wvalid, e_accept, e_b, e_b_known;
  logic      e_bready, e_bypass, e_out_valid, e_in_ready;
  rw_write_t e_out;
  logic [31:0] e_awaddr;

  always_comb begin
    e_wr        = !rst && task_in_valid && task_in_wr;
    e_hold      = m_out[task_in.thread];
    e_awvalid   = e_wr && !e_hold && !m_addr_sent;
    e_wvalid    = e_wr && !e_hold && !m_data_sent;
    e_accept    = e_wr && !e_hold && (m_addr_sent || awready) && (m_data_sent || wready);
    e_b         = !rst && bvalid;
    e_b_known   = m_out[bid];
    e_bready    = e_b && task_out_ready;
    e_bypass    = !rst && task_in_valid && !task_in_wr;
    e_out_valid = e_b ? e_b_known : e_bypass;
    e_out       = e_b ? m_slot[bid] : task_in;
    e_in_ready  = e_accept || (e_bypass && task_out_ready && !bvalid);
    e_awaddr    = m_base + 32'(task_in.task_desc.locale) * 32'd4;
  end

  function automatic logic [63:0] strb_of(input logic [15:0] loc);
    logic [63:0] s = '0;
    for (int w = 0; w < 16; w++) if (w == int'(loc % 16'd16)) s[w*4 +: 4] = 4'hF;
    return s;
  endfunction

  function automatic logic [511:0] data_of(input logic [31:0] obj);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = obj;
    return d;
  endfunction

  function automatic logic [31:0] reg_read(input logic [15:0] a);
    if (a == RW_WRITE_ERR) return {31'b0, m_err};
`ifdef WRITE_RW_STATS_EN
    if (a == RW_WRITE_STAT_BASE) return m_cnt[0];
    if (a == RW_WRITE_STAT_BASE + 16'd4) return m_cnt[1];
    if (a == RW_WRITE_STAT_BASE + 16'd8) return m_cnt[2];
`endif
    return 32'd0;
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_out[i] <= 1'b0;
      m_addr_sent <= 1'b0;
      m_data_sent <= 1'b0;
      m_base      <= '0;
      m_err       <= 1'b0;
      m_rvalid    <= 1'b0;
      m_rdata     <= '0;
      for (int i = 0; i < 3; i++) m_cnt[i] <= '0;
    end else begin
      if (e_accept) begin
        m_addr_sent            <= 1'b0;
        m_data_sent            <= 1'b0;
        m_out[task_in.thread]  <= 1'b1;
        m_slot[task_in.thread] <= task_in;
      end else begin
        if (e_awvalid && awready) m_addr_sent <= 1'b1;
        if (e_wvalid && wready)   m_data_sent <= 1'b1;
      end
      if (e_bready) begin
        if (e_b_known) m_out[bid] <= 1'b0;
        else           m_err      <= 1'b1;
      end
      if (reg_bus.wvalid && reg_bus.waddr == RW_BASE_ADDR) m_base <= reg_bus.wdata * 32'd4;
      m_rvalid <= reg_bus.arvalid;
      m_rdata  <= reg_read(reg_bus.araddr);
      if (reg_bus.wvalid && reg_bus.waddr == RW_WRITE_STAT_BASE) begin
        for (int i = 0; i < 3; i++) m_cnt[i] <= '0;
      end else begin
        if (e_accept) m_cnt[0] <= sat1(m_cnt[0]);
        if (e_bypass && e_in_ready) m_cnt[1] <= sat1(m_cnt[1]);
        if (task_in_valid && !e_in_ready) m_cnt[2] <= sat1(m_cnt[2]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("awvalid", 512'(awvalid), 512'(e_awvalid));
    chk("wvalid", 512'(wvalid), 512'(e_wvalid));
    chk("task_in_ready", 512'(task_in_ready), 512'(e_in_ready));
    chk("bready", 512'(bready), 512'(e_bready));
    chk("task_out_valid", 512'(task_out_valid), 512'(e_out_valid));
    chk("rvalid", 512'(reg_rsp.rvalid), 512'(m_rvalid));
    if (e_awvalid) begin
      chk("awaddr", 512'(awaddr), 512'(e_awaddr));
      chk("awid", 512'(awid), 512'(task_in.thread));
    end
    if (e_wvalid) begin
      chk("wdata", wdata, data_of(task_in.object));
      chk("wstrb", 512'(wstrb), 512'(strb_of(task_in.task_desc.locale)));
    end
    if (e_out_valid) chk("task_out", 512'(task_out), 512'(e_out));
    if (m_rvalid) chk("rdata", 512'(reg_rsp.rdata), 512'(m_rdata));
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic rw_write_t mk(input thread_id_t th, input logic [15:0] loc,
                                   input logic [31:0] obj);
    rw_write_t t;
    t.task_desc.ts     = obj ^ 32'h5A5A_0000;
    t.task_desc.locale = loc;
    t.task_desc.ttype  = 8'(th) + 8'h40;
    t.cq_slot          = 8'(loc) + 8'h10;
    t.thread           = th;
    t.object           = obj;
    t.cache_addr       = {16'hCA00, loc};
    return t;
  endfunction

  task automatic idle();
    task_in_valid  = 1'b0;
    task_in_wr     = 1'b0;
    task_in        = '0;
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b0;
    bid            = '0;
    task_out_ready = 1'b1;
    reg_bus        = '0;
  endtask

  task automatic send_b(input id_t id);
    bvalid = 1'b1;
    bid    = id;
    tick();
    bvalid = 1'b0;
  endtask

  int aw_hs;

  initial begin
    idle();
    task_in       = mk(4'd1, 16'd1, 32'h1);
    task_in_valid = 1'b1;
    task_in_wr    = 1'b1;
    awready       = 1'b1;
    wready        = 1'b1;
    tick();
    at_neg();
    chk("rst_awvalid", 512'(awvalid), 512'(0));
    chk("rst_task_in_ready", 512'(task_in_ready), 512'(0));
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Scenario 1: base 0x1000, locale 5, thread 3
    reg_bus.wvalid = 1'b1;
    reg_bus.waddr  = RW_BASE_ADDR;
    reg_bus.wdata  = 32'h0000_0400;
    tick();
    reg_bus = '0;
    task_in = mk(4'd3, 16'd5, 32'hDEAD_BEEF);
    task_in_valid = 1'b1; task_in_wr = 1'b1; awready = 1'b1; wready = 1'b1;
    at_neg();
    chk("s1_awaddr", 512'(awaddr), 512'(32'h0000_1014));
    chk("s1_wstrb", 512'(wstrb), 512'(64'h0000_0000_00F0_0000));
    chk("s1_ready", 512'(task_in_ready), 512'(1));
    tick();
    task_in_valid = 1'b0;
    bvalid = 1'b1; bid = 4'd3;
    at_neg();
    chk("s1_out_valid", 512'(task_out_valid), 512'(1));
    chk("s1_out_obj", 512'(task_out.object), 512'(32'hDEAD_BEEF));
    chk("s1_out_thread", 512'(task_out.thread), 512'(3));
    tick();
    bvalid = 1'b0;

    // Scenario 2: W stalls until cycle 4, AW accepted once
    task_in = mk(4'd4, 16'd1, 32'h1111_2222);
    task_in_valid = 1'b1; task_in_wr = 1'b1; awready = 1'b1; wready = 1'b0;
    aw_hs = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) wready = 1'b1;
      at_neg();
      if (awvalid && awready) aw_hs++;
      chk("s2_ready_cycle", 512'(task_in_ready), 512'(c == 4));
      tick();
    end
    task_in_valid = 1'b0;
    chk("s2_aw_count", 512'(aw_hs), 512'(1));
    send_b(4'd4);

    // Scenario 3: B beats a bypass task
    task_in = mk(4'd6, 16'd0, 32'hA5A5_A5A5);
    task_in_valid = 1'b1; task_in_wr = 1'b1;
    tick();
    task_in = mk(4'd9, 16'd2, 32'h0000_0099);
    task_in_wr = 1'b0;
    bvalid = 1'b1; bid = 4'd6;
    at_neg();
    chk("s3_b_first_thread", 512'(task_out.thread), 512'(6));
    chk("s3_b_first_obj", 512'(task_out.object), 512'(32'hA5A5_A5A5));
    chk("s3_bypass_held", 512'(task_in_ready), 512'(0));
    tick();
    bvalid = 1'b0;
    at_neg();
    chk("s3_bypass_thread", 512'(task_out.thread), 512'(9));
    chk("s3_bypass_ready", 512'(task_in_ready), 512'(1));
    chk("s3_bypass_no_aw", 512'(awvalid), 512'(0));
    tick();
    task_in_valid = 1'b0;

    // Scenario 4: second write on pending thread 2
    task_in = mk(4'd2, 16'd7, 32'h0000_0022);
    task_in_valid = 1'b1; task_in_wr = 1'b1;
    tick();
    task_in = mk(4'd2, 16'd8, 32'h0000_0033);
    for (int c = 0; c < 2; c++) begin
      at_neg();
      chk("s4_held", 512'(awvalid), 512'(0));
      tick();
    end
    bvalid = 1'b1; bid = 4'd2;
    at_neg();
    chk("s4_held_on_b", 512'(awvalid), 512'(0));
    chk("s4_b_obj", 512'(task_out.object), 512'(32'h22));
    tick();
    bvalid = 1'b0;
    at_neg();
    chk("s4_issue", 512'(awvalid), 512'(1));
    chk("s4_awaddr", 512'(awaddr), 512'(32'h0000_1020));
    tick();
    task_in_valid = 1'b0;
    send_b(4'd2);

    // Scenario 5: stray response on thread 7
    bvalid = 1'b1; bid = 4'd7;
    at_neg();
    chk("s5_bready", 512'(bready), 512'(1));
    chk("s5_no_out", 512'(task_out_valid), 512'(0));
    tick();
    bvalid = 1'b0;
    reg_bus.arvalid = 1'b1; reg_bus.araddr = RW_WRITE_ERR;
    tick();
    reg_bus.araddr = RW_BASE_ADDR;
    at_neg();
    chk("s5_err_rvalid", 512'(reg_rsp.rvalid), 512'(1));
    chk("s5_err_rdata", 512'(reg_rsp.rdata), 512'(1));
    tick();
    reg_bus = '0;
    at_neg();
    chk("s5_base_reads_0", 512'(reg_rsp.rdata), 512'(0));
    tick();

    // Scenario 6: reset while an address beat is latched
    task_in = mk(4'd10, 16'd2, 32'h0000_00AA);
    task_in_valid = 1'b1; task_in_wr = 1'b1; awready = 1'b1; wready = 1'b1;
    tick();
    task_in = mk(4'd8, 16'd3, 32'h0000_00BB);
    wready = 1'b0;
    tick();
    at_neg();
    chk("s6_aw_latched", 512'(awvalid), 512'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    chk("s6_aw_reissue", 512'(awvalid), 512'(1));
    chk("s6_w_reissue", 512'(wvalid), 512'(1));
    chk("s6_awaddr_base0", 512'(awaddr), 512'(32'h0000_000C));
    wready = 1'b1;
    tick();
    task_in = mk(4'd10, 16'd2, 32'h0000_00CC);
    at_neg();
    chk("s6_pending_cleared", 512'(awvalid), 512'(1));
    chk("s6_awaddr10", 512'(awaddr), 512'(32'h0000_0008));
    tick();
    task_in_valid = 1'b0;
    reg_bus.arvalid = 1'b1; reg_bus.araddr = RW_WRITE_ERR;
    tick();
    reg_bus = '0;
    at_neg();
    chk("s6_err_cleared", 512'(reg_rsp.rdata), 512'(0));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
